// File: rtl/pll_phase_sweeper_if.sv
// Bundles the request side and the PLL phase-shift port of pll_phase_sweeper.
// Ports: slave  = the sweeper (takes requests and PLL status; drives status and PLL controls)
//        master = the environment (calibration FSM plus PLL).
interface pll_phase_sweeper_if #(
  parameter int STEP_W = 8,
  parameter int POS_W  = 6
);
  // request / status side
  logic              start;
  logic [STEP_W-1:0] step_cnt_in;
  logic              updn_in;
  logic [4:0]        cntsel_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [POS_W-1:0]  phase_pos;
  // PLL phase-shift port
  logic              pll_locked;
  logic              pll_phase_en;
  logic              pll_updn;
  logic [4:0]        pll_cntsel;
  logic              pll_phase_done;

  modport slave (
    input  start, step_cnt_in, updn_in, cntsel_in, pll_locked, pll_phase_done,
    output busy, done, err, phase_pos, pll_phase_en, pll_updn, pll_cntsel
  );

  modport master (
    output start, step_cnt_in, updn_in, cntsel_in, pll_locked, pll_phase_done,
    input  busy, done, err, phase_pos, pll_phase_en, pll_updn, pll_cntsel
  );
endinterface

// File: rtl/pll_phase_sweeper.sv
// Sequences a multi-step dynamic phase shift on the PLL: one phase_en/phase_done handshake
// per step, after lock; tracks the accumulated phase position modulo one output period.
// Ports: scanclk (single clock), rst_n (async active-low), bus (pll_phase_sweeper_if.slave):
//   request start/step_cnt_in/updn_in/cntsel_in, status busy/done/err/phase_pos,
//   PLL pll_locked (async, synchronised here)/pll_phase_en/pll_updn/pll_cntsel/pll_phase_done.
// Optional feature: define PHASE_TIMEOUT_EN to add a handshake watchdog (TIMEOUT_CYCLES).
module pll_phase_sweeper #(
  parameter int STEP_W           = 8,
  parameter int STEPS_PER_PERIOD = 64,
  parameter int POS_W            = 6,
  parameter int SETUP_CYCLES     = 2,
`ifdef PHASE_TIMEOUT_EN
  parameter int EN_CYCLES        = 2,
  parameter int TIMEOUT_CYCLES   = 1023
`else
  parameter int EN_CYCLES        = 2
`endif
) (
  input  logic                  scanclk,
  input  logic                  rst_n,
  pll_phase_sweeper_if.slave    bus
);

  // shared down-counter for the SETUP and PULSE dwell times
  localparam int PH_MAX = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int CNT_W  = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(STEPS_PER_PERIOD - 1);

`ifdef PHASE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_SETUP, S_PULSE, S_WAIT_DONE, S_GAP, S_FINISH, S_ERROR
  } state_t;

  state_t            state;
  logic              lock_meta;
  logic              lock_sync;
  logic [STEP_W-1:0] remaining;
  logic              req_updn;
  logic [4:0]        req_cntsel;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [POS_W-1:0]  pos_q;
  logic              phase_en_q;
  logic              updn_q;
  logic [4:0]        cntsel_q;
`ifdef PHASE_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_cnt;
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.phase_pos    = pos_q;
  assign bus.pll_phase_en = phase_en_q;
  assign bus.pll_updn     = updn_q;
  assign bus.pll_cntsel   = cntsel_q;

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lock_meta  <= 1'b0;
      lock_sync  <= 1'b0;
      remaining  <= '0;
      req_updn   <= 1'b0;
      req_cntsel <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
      phase_en_q <= 1'b0;
      updn_q     <= 1'b0;
      cntsel_q   <= '0;
`ifdef PHASE_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      lock_meta <= bus.pll_locked;
      lock_sync <= lock_meta;
      done_q    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            req_updn   <= bus.updn_in;
            req_cntsel <= bus.cntsel_in;
            remaining  <= bus.step_cnt_in;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            // a zero-step request completes without touching the PLL
            state      <= (bus.step_cnt_in == '0) ? S_FINISH : S_WAIT_LOCK;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_sync) begin
            cntsel_q <= req_cntsel;
            updn_q   <= req_updn;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (!lock_sync) begin
            state <= S_ERROR;
          end else if (cnt == SETUP_LAST) begin
            cnt        <= '0;
            phase_en_q <= 1'b1;
`ifdef PHASE_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
            state      <= S_PULSE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PULSE: begin
          if (!lock_sync) begin
            phase_en_q <= 1'b0;
            state      <= S_ERROR;
`ifdef PHASE_TIMEOUT_EN
          end else if (tmo_cnt == TMO_LAST) begin
            phase_en_q <= 1'b0;
            state      <= S_ERROR;
`endif
          end else if ((cnt >= EN_LAST) && !bus.pll_phase_done) begin
            // PLL has acknowledged the shift and the minimum width is met
            phase_en_q <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
            state      <= S_WAIT_DONE;
          end else begin
            if (cnt < EN_LAST) cnt <= cnt + CNT_W'(1);
`ifdef PHASE_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end

        S_WAIT_DONE: begin
          if (!lock_sync) begin
            state <= S_ERROR;
`ifdef PHASE_TIMEOUT_EN
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_ERROR;
`endif
          end else if (bus.pll_phase_done) begin
            if (req_updn) pos_q <= (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            else          pos_q <= (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
            remaining <= remaining - STEP_W'(1);
            state     <= S_GAP;
`ifdef PHASE_TIMEOUT_EN
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end

        S_GAP: begin
          if (!lock_sync) begin
            state <= S_ERROR;
          end else if (remaining != '0) begin
            cnt   <= '0;
            state <= S_SETUP;
          end else begin
            state <= S_FINISH;
          end
        end

        S_FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        S_ERROR: begin
          err_q  <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_sweeper.sv
// Directed bench for pll_phase_sweeper with a small behavioural PLL phase-shift responder.
module tb_pll_phase_sweeper;
  logic scanclk = 1'b0;
  logic rst_n   = 1'b0;

  pll_phase_sweeper_if #(.STEP_W(8), .POS_W(6)) bus ();

  pll_phase_sweeper dut (
    .scanclk (scanclk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 scanclk = ~scanclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // PLL responder: phase_done low after phase_en seen, high again 2 cycles after it falls
  int pm  = 0;
  int dly = 0;
  initial begin
    forever begin
      @(negedge scanclk);
      case (pm)
        0: if (bus.pll_phase_en) begin bus.pll_phase_done = 1'b0; pm = 1; end
        1: if (!bus.pll_phase_en) begin pm = 2; dly = 2; end
        default: begin
          if (dly <= 1) begin bus.pll_phase_done = 1'b1; pm = 0; end
          else dly--;
        end
      endcase
    end
  end

  // monitor: phase_en pulse count, short pulses, done pulses
  int   pulses = 0;
  int   short_pulses = 0;
  int   done_cnt = 0;
  int   width = 0;
  logic en_prev = 1'b0;
  initial begin
    forever begin
      @(negedge scanclk);
      if (bus.pll_phase_en && !en_prev) pulses++;
      if (bus.pll_phase_en) width++;
      if (!bus.pll_phase_en && en_prev) begin
        if (width < 2) short_pulses++;
        width = 0;
      end
      if (bus.done) done_cnt++;
      en_prev = bus.pll_phase_en;
    end
  end

  task automatic tick();
    @(negedge scanclk);
    #1;
  endtask

  task automatic issue(input logic [7:0] n, input logic u, input logic [4:0] cs);
    bus.start       = 1'b1;
    bus.step_cnt_in = n;
    bus.updn_in     = u;
    bus.cntsel_in   = cs;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!bus.done && !bus.err && n < 400) begin
      tick();
      n++;
    end
    chk(tag, (n < 400), 1);
  endtask

  int pb, db, lat;

  initial begin
    bus.start = 1'b0; bus.step_cnt_in = '0; bus.updn_in = 1'b0; bus.cntsel_in = '0;
    bus.pll_locked = 1'b1; bus.pll_phase_done = 1'b1;
    repeat (3) tick();
    // reset values
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_pos", bus.phase_pos, 0);
    chk("rst_en", bus.pll_phase_en, 0);
    chk("rst_updn", bus.pll_updn, 0);
    chk("rst_cntsel", bus.pll_cntsel, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // A: 3 positive steps from 0
    pb = pulses; db = done_cnt;
    issue(8'd3, 1'b1, 5'b00001);
    chk("a_busy", bus.busy, 1);
    wait_end("a_end");
    tick();
    chk("a_pulses", pulses - pb, 3);
    chk("a_short", short_pulses, 0);
    chk("a_done", done_cnt - db, 1);
    chk("a_err", bus.err, 0);
    chk("a_pos", bus.phase_pos, 3);
    chk("a_cntsel", bus.pll_cntsel, 5'b00001);
    chk("a_updn", bus.pll_updn, 1);
    chk("a_busy_end", bus.busy, 0);

    // B: down 2 to reach 1, then down 3 wrapping through 0 -> 63 -> 62
    issue(8'd2, 1'b0, 5'b00010);
    wait_end("b1_end");
    tick();
    chk("b1_pos", bus.phase_pos, 1);
    issue(8'd3, 1'b0, 5'b00010);
    wait_end("b2_end");
    tick();
    chk("b2_pos", bus.phase_pos, 62);
    chk("b2_updn", bus.pll_updn, 0);

    // C: zero-step request
    pb = pulses; db = done_cnt;
    issue(8'd0, 1'b1, 5'b11111);
    chk("c_busy", bus.busy, 1);
    chk("c_done_early", bus.done, 0);
    tick();
    chk("c_done", bus.done, 1);
    chk("c_busy_off", bus.busy, 0);
    tick();
    chk("c_done_once", bus.done, 0);
    chk("c_pulses", pulses - pb, 0);
    chk("c_pos", bus.phase_pos, 62);
    chk("c_cntsel_held", bus.pll_cntsel, 5'b00010);

    // D: start without lock, lock arrives 20 cycles later
    bus.pll_locked = 1'b0;
    repeat (4) tick();
    pb = pulses;
    issue(8'd1, 1'b1, 5'b00100);
    repeat (20) tick();
    chk("d_no_en", pulses - pb, 0);
    chk("d_busy", bus.busy, 1);
    bus.pll_locked = 1'b1;
    lat = 0;
    while (!bus.pll_phase_en && lat < 50) begin
      tick();
      lat++;
    end
    chk("d_lock_lat", (lat >= 3 && lat < 50), 1);
    wait_end("d_end");
    tick();
    chk("d_pos", bus.phase_pos, 63);

    // E: lose lock during step 2 of 4 (first step wraps 63 -> 0)
    pb = pulses; db = done_cnt;
    issue(8'd4, 1'b1, 5'b00011);
    lat = 0;
    while ((pulses - pb) < 2 && lat < 200) begin
      tick();
      lat++;
    end
    chk("e_reach_step2", (lat < 200), 1);
    bus.pll_locked = 1'b0;
    wait_end("e_end");
    chk("e_err", bus.err, 1);
    chk("e_en_low", bus.pll_phase_en, 0);
    chk("e_pos", bus.phase_pos, 0);
    tick();
    chk("e_no_done", done_cnt - db, 0);
    chk("e_busy", bus.busy, 0);
    chk("e_err_sticky", bus.err, 1);

    // F: relock, new start clears err; start while busy is ignored
    bus.pll_locked = 1'b1;
    repeat (4) tick();
    db = done_cnt;
    issue(8'd1, 1'b1, 5'b00101);
    chk("f_err_clr", bus.err, 0);
    tick();
    issue(8'd5, 1'b0, 5'b01000);
    wait_end("f_end");
    tick();
    repeat (10) tick();
    chk("f_pos", bus.phase_pos, 1);
    chk("f_done", done_cnt - db, 1);
    chk("f_cntsel", bus.pll_cntsel, 5'b00101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
